// File: rtl/fifo_serial_tx.sv
// FIFO-fed UART-style transmitter: pops one word, sends start, DATA_W bits LSB first, stop.
// Optional even-parity bit between data and stop when FIFO_SERIAL_TX_PARITY_EN is defined.
module fifo_serial_tx #(
  parameter int DATA_W   = 10,
  parameter int BAUD_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_val,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = (DATA_W   > 1) ? $clog2(DATA_W)   : 1;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic [CW-1:0]     baud_cnt, baud_nx;
  logic [DATA_W-1:0] shreg, sh_nx;
  logic              tx_nx, busy_nx, done_nx;
  logic              last;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic              par, par_nx;
`endif

  // Gated by reset so no pop strobe leaks out while the block is held in reset.
  assign fifo_read = reset & (state == IDLE) & fifo_val & enable;
  assign last      = (baud_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_nx;
      baud_cnt <= baud_nx;
      shreg    <= sh_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par      <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    baud_nx  = baud_cnt;
    sh_nx    = shreg;
    tx_nx    = tx;
    busy_nx  = busy;
    done_nx  = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    par_nx   = par;
`endif
    if (state != IDLE) baud_nx = last ? '0 : baud_cnt + CW'(1);
    case (state)
      IDLE: if (fifo_read) begin
        sh_nx    = fifo_data;
        state_nx = START;
        tx_nx    = 1'b0;
        busy_nx  = 1'b1;
        baud_nx  = '0;
        bit_nx   = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        par_nx   = ^fifo_data;
`endif
      end
      START: if (last) begin
        state_nx = DATA;
        bit_nx   = '0;
        tx_nx    = shreg[0];
      end
      DATA: if (last) begin
        sh_nx = shreg >> 1;
        if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          state_nx = PARITY;
          tx_nx    = par;
`else
          state_nx = STOP;
          tx_nx    = 1'b1;
`endif
        end else begin
          bit_nx = bit_cnt + BW'(1);
          tx_nx  = sh_nx[0];
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: if (last) begin
        state_nx = STOP;
        tx_nx    = 1'b1;
      end
`endif
      STOP: if (last) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        bit_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Randomized bench for fifo_serial_tx against a frame-level model (bit list indexed by cycle/BAUD_DIV).
module tb_fifo_serial_tx;
  localparam int DW = 10;
  localparam int BD = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int FL = (DW + 3) * BD;
`else
  localparam int FL = (DW + 2) * BD;
`endif

  logic          clock = 1'b0, reset = 1'b0, enable = 1'b0, fifo_val = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read, tx, busy, done;

  fifo_serial_tx #(.DATA_W(DW), .BAUD_DIV(BD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_data(fifo_data),
    .fifo_val(fifo_val), .fifo_read(fifo_read), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  // model: t = cycle index inside current frame, -1 when idle
  int            t = -1;
  bit            dflag = 1'b0;
  bit            fbits[$];
  logic [DW-1:0] q[$];
  bit            gate = 1'b1;
  int            cyc = 0;
  int            pop_cyc[$];
  int            done_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void build(input logic [DW-1:0] w);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < DW; i++) fbits.push_back(w[i]);
`ifdef FIFO_SERIAL_TX_PARITY_EN
    fbits.push_back(^w);
`endif
    fbits.push_back(1'b1);
  endfunction

  // Called at a falling edge; checks the current cycle and advances the model over the next rising edge.
  task automatic cycle();
    logic exp_pop, exp_tx;
    fifo_val  = gate && (q.size() > 0);
    fifo_data = (q.size() > 0) ? q[0] : DW'($urandom);
    #1;
    exp_pop = reset && (t < 0) && fifo_val && enable;
    exp_tx  = (t < 0) ? 1'b1 : fbits[t / BD];
    chk("fifo_read", 32'(fifo_read), 32'(exp_pop));
    chk("tx", 32'(tx), 32'(exp_tx));
    chk("busy", 32'(busy), 32'(t >= 0));
    chk("done", 32'(done), 32'(dflag));
    if (fifo_read === 1'b1) pop_cyc.push_back(cyc);
    if (done === 1'b1) done_cyc.push_back(cyc);
    @(posedge clock);
    dflag = 1'b0;
    if (!reset) t = -1;
    else if (t >= 0) begin
      t++;
      if (t == FL) begin t = -1; dflag = 1'b1; end
    end else if (exp_pop) begin
      build(q.pop_front());
      t = 0;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    @(negedge clock);
    // reset held with a word waiting, then first pop right on release
    q.push_back(10'h155);
    enable = 1'b1;
    run(3);
    reset = 1'b1;
    run(FL + 3);

    // single word 2A5, latency from first start cycle to done
    pop_cyc.delete(); done_cyc.delete();
    q.push_back(10'h2A5);
    run(FL + 4);
    chk("pop_cnt_2a5", 32'(pop_cyc.size()), 32'd1);
    chk("done_cnt_2a5", 32'(done_cyc.size()), 32'd1);
    if (pop_cyc.size() == 1 && done_cyc.size() == 1)
      chk("done_lat", 32'(done_cyc[0] - (pop_cyc[0] + 1)), 32'(FL));

    // back-to-back words 1,2,3
    pop_cyc.delete(); done_cyc.delete();
    q.push_back(10'd1); q.push_back(10'd2); q.push_back(10'd3);
    run(3 * (FL + 1) + 6);
    chk("pop_cnt_123", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("pop_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'(FL + 1));
      chk("pop_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'(FL + 1));
    end

    // enable low blocks pops; dropping it mid-frame does not abort
    pop_cyc.delete();
    enable = 1'b0;
    q.push_back(10'h0F0); q.push_back(10'h30C);
    run(20);
    chk("pop_en0", 32'(pop_cyc.size()), 32'd0);
    enable = 1'b1;
    run(3);
    enable = 1'b0;
    run(FL + 6);
    chk("pop_en_drop", 32'(pop_cyc.size()), 32'd1);
    q.delete();
    enable = 1'b1;

    // async reset during data bit 5 of 3FF
    done_cyc.delete();
    q.push_back(10'h3FF);
    run(1 + BD * 6 + 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(fifo_read), 32'd0);
    t = -1; dflag = 1'b0;
    @(negedge clock);
    run(2);
    reset = 1'b1;
    run(FL + 4);
    chk("rst_no_done", 32'(done_cyc.size()), 32'd0);

    // fifo_val toggling during a frame
    pop_cyc.delete();
    q.push_back(10'h1C3); q.push_back(10'h2B4);
    for (int i = 0; i < 2 * (FL + 1) + 12; i++) begin
      gate = (i % 4) == 0;
      cycle();
    end
    gate = 1'b1;
    chk("pop_toggle", 32'(pop_cyc.size()), 32'd2);

    // randomized traffic
    q.delete();
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 8) == 0 && q.size() < 4) q.push_back(DW'($urandom));
      enable = ($urandom % 4) != 0;
      gate   = ($urandom % 3) != 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Downstream consumer of the project FIFO (`fifo` module).
- Pops one word at a time through the FIFO val/read handshake and transmits it on a single-wire, UART-style serial line.
- Frame format: start bit, DATA_W data bits sent LSB first, optional parity bit, stop bit.
- Connects directly to the FIFO outputs dataout/val and drives the FIFO read input.

Parameters:
- DATA_W, 10, width of a FIFO word and number of data bits per frame; must match the FIFO DATA_W.
- BAUD_DIV, 4, clock cycles per serial bit; legal range is 1 or more.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, regardless of clock.
- enable  input  1  permits starting a new frame; does not affect a frame in progress.
- fifo_data  input  DATA_W  head word from the FIFO dataout.
- fifo_val  input  1  FIFO holds a valid head word.
- fifo_read  output  1  pop strobe to the FIFO read input.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset values (reset low): tx=1, busy=0, done=0, fifo_read=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States: IDLE, START, DATA, PARITY (present only with the feature), STOP.
- IDLE:
  - fifo_read = (state==IDLE) & fifo_val & enable; this is combinational, so the pop happens in the same cycle val is seen.
  - On a clock edge with fifo_read=1: latch fifo_data into the shift register, go to START, set busy=1.
  - fifo_read is never high outside IDLE; at most one pop per frame.
- Bit timing:
  - tx is registered.
  - Each bit holds tx stable for exactly BAUD_DIV cycles, timed by a baud counter that counts 0..BAUD_DIV-1.
  - The state or bit index advances when the counter reaches BAUD_DIV-1.
- START: tx=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0; shift right on each bit boundary.
  - After bit index DATA_W-1, go to PARITY if compiled in, otherwise to STOP.
- STOP:
  - tx=1 for one bit time.
  - On its last cycle: done=1 for one cycle, busy=0, go to IDLE.
- Latency and throughput:
  - The first start-bit cycle on tx is the cycle after the pop edge.
  - Frame length is (DATA_W+2)*BAUD_DIV cycles, plus BAUD_DIV with parity.
  - There is a minimum of 1 IDLE cycle between frames. With continuous fifo_val, the frame period is frame length + 1.
- enable:
  - Deasserting enable mid-frame does not abort; the frame completes.
  - No new pop occurs while enable=0.
- Empty FIFO (fifo_val=0): stay in IDLE, tx=1, no pop.
- FIFO going empty mid-frame: no effect, because the word is already latched.
- Reset asserted mid-frame: tx returns to 1 asynchronously. The latched word is discarded, no done pulse is produced, and there is no re-pop on release.
- Reset release: the first pop may occur on the first rising edge with reset high.
- fifo_data is ignored except on the pop edge.

Optional Feature:
- Macro: FIFO_SERIAL_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - tx = even-parity bit = XOR of all DATA_W data bits, held for one bit time.
  - Frame length becomes (DATA_W+3)*BAUD_DIV.
- Undefined:
  - No PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan (DATA_W=10, BAUD_DIV=4):
- Reset held low with fifo_val=1 -> fifo_read=0, tx=1, busy=0 throughout. Reset release with fifo_val=1, enable=1 -> fifo_read=1 on the first cycle; tx=0 on the following 4 cycles.
- Pop 10'h2A5 -> tx sequence per 4-cycle bit: 0 (start), then 1,0,1,0,0,1,0,1,0,1, then 1 (stop). done pulses once, 48 cycles after the first start cycle's edge. With the parity feature: parity bit 1 before stop, and the frame is 52 cycles.
- FIFO preloaded with 1, 2, 3, fifo_val held high -> exactly 3 fifo_read pulses, spaced 49 cycles apart. Decoded words are 1, 2, 3 in order. tx idles at 1 after the third done.
- enable=0 with fifo_val=1 for 20 cycles -> no fifo_read, tx=1. Then set enable=1 and drop it 2 cycles into the frame -> the frame completes, and no second pop occurs.
- Reset pulled low during data bit 5 of word 10'h3FF -> tx=1 immediately and busy=0. After release with fifo_val=0 -> tx stays 1 and no done pulse occurs.
- fifo_val toggling 1 cycle high, 3 low, during an active frame -> fifo_read stays 0 until IDLE. tx waveform is unaffected.
